// File: rtl/sa_pkg.sv
// rtl/sa_pkg.sv - shared types and constants for the systolic array job sequencer
package sa_pkg;

  localparam int SA_N              = 4;
  localparam int SA_DW             = 8;
  localparam int SA_AW             = 8;
  localparam int SA_COMPUTE_CYCLES = 15;
  localparam int CLEAR_CYCLES      = 2;

  // Lane x of a packed word occupies [x*SA_LANE_W +: SA_LANE_W]
  localparam int SA_LANE_W = SA_DW;
  localparam int SA_WORD_W = SA_N * SA_LANE_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_CLEAR,
    S_LOAD,
    S_COMPUTE,
    S_DRAIN,
    S_DONE
  } sa_seq_state_t;

endpackage

// File: rtl/sa_operand_stage.sv
// rtl/sa_operand_stage.sv - 2N-word operand staging buffer (A words 0..N-1, B words N..2N-1)
module sa_operand_stage
  import sa_pkg::*;
#(
  parameter int N  = SA_N,
  parameter int DW = SA_DW
) (
  input  logic                    clk,
  input  logic                    wr_en,
  input  logic [$clog2(2*N)-1:0]  wr_idx,
  input  logic [N*DW-1:0]         wr_data,
  input  logic [$clog2(N)-1:0]    rd_idx,
  output logic [N*DW-1:0]         rd_a,
  output logic [N*DW-1:0]         rd_b
);

  localparam int IW = $clog2(2*N);

  // Contents are refilled by every job before use, so no reset is needed
  logic [N*DW-1:0] stage_mem [2*N];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      stage_mem[wr_idx] <= wr_data;
    end
  end

  assign rd_a = stage_mem[IW'(rd_idx)];
  assign rd_b = stage_mem[IW'(rd_idx) + IW'(N)];

endmodule

// File: rtl/sa_job_sequencer.sv
// rtl/sa_job_sequencer.sv - fetch/clear/load/compute/drain job controller for the 4x4 systolic array
module sa_job_sequencer
  import sa_pkg::*;
#(
  parameter int N              = SA_N,
  parameter int DW             = SA_DW,
  parameter int AW             = SA_AW,
  parameter int COMPUTE_CYCLES = SA_COMPUTE_CYCLES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [AW-1:0]     base_a,
  input  logic [AW-1:0]     base_b,
  input  logic [AW-1:0]     base_c,
  output logic              busy,
  output logic              done,
  output logic              mem_rd_en,
  output logic [AW-1:0]     mem_rd_addr,
  input  logic [N*DW-1:0]   mem_rd_data,
  output logic              sa_rstn,
  output logic              sa_en,
  output logic [N*DW-1:0]   sa_shift_a,
  output logic [N*DW-1:0]   sa_shift_b,
  input  logic [N*DW-1:0]   sa_shift_out,
  output logic              res_wr_en,
  output logic [AW-1:0]     res_wr_addr,
  output logic [N*DW-1:0]   res_wr_data
);

  localparam int WW           = N * DW;
  localparam int FETCH_CYCLES = 2 * N + 1;
  localparam int MAX_CYCLES   = (COMPUTE_CYCLES > FETCH_CYCLES) ? COMPUTE_CYCLES : FETCH_CYCLES;
  localparam int CW           = $clog2(MAX_CYCLES + 1);
  localparam int IW           = $clog2(2 * N);
  localparam int LW           = $clog2(N);

  sa_seq_state_t state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          last;
  logic [AW-1:0] base_a_q, base_b_q, base_c_q;

  logic          stage_wr_en;
  logic [IW-1:0] stage_wr_idx;
  logic [LW-1:0] stage_rd_idx;
  logic [WW-1:0] stage_rd_a, stage_rd_b;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      base_a_q <= '0;
      base_b_q <= '0;
      base_c_q <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (state == S_IDLE && start) begin
        base_a_q <= base_a;
        base_b_q <= base_b;
        base_c_q <= base_c;
      end
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt + CW'(1);
    last        = 1'b0;
    busy        = (state != S_IDLE);
    done        = 1'b0;
    mem_rd_en   = 1'b0;
    mem_rd_addr = '0;
    sa_rstn     = 1'b1;
    sa_en       = 1'b0;
    sa_shift_a  = '0;
    sa_shift_b  = '0;
    res_wr_en   = 1'b0;
    res_wr_addr = '0;
    res_wr_data = '0;
    stage_wr_en = 1'b0;
    case (state)
      S_IDLE: begin
        cnt_nxt = '0;
        if (start) state_nxt = S_FETCH;
      end
      S_FETCH: begin
        last = (cnt == CW'(FETCH_CYCLES - 1));
        if (cnt < CW'(N)) begin
          mem_rd_en   = 1'b1;
          mem_rd_addr = base_a_q + AW'(cnt);
        end else if (cnt < CW'(2 * N)) begin
          mem_rd_en   = 1'b1;
          mem_rd_addr = base_b_q + AW'(cnt - CW'(N));
        end
        // Read data lags the strobe by one cycle, so step f stores word f-1
        stage_wr_en = (cnt != '0);
        if (last) state_nxt = S_CLEAR;
      end
      S_CLEAR: begin
        sa_rstn = 1'b0;
        last    = (cnt == CW'(CLEAR_CYCLES - 1));
        if (last) state_nxt = S_LOAD;
      end
      S_LOAD: begin
        sa_en      = 1'b1;
        sa_shift_a = stage_rd_a;
        sa_shift_b = stage_rd_b;
        last       = (cnt == CW'(N - 1));
        if (last) state_nxt = S_COMPUTE;
      end
      S_COMPUTE: begin
        last = (cnt == CW'(COMPUTE_CYCLES - 1));
        if (last) state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        res_wr_en   = 1'b1;
        res_wr_addr = base_c_q + AW'(cnt);
        res_wr_data = sa_shift_out;
        last        = (cnt == CW'(N - 1));
        if (last) state_nxt = S_DONE;
      end
      S_DONE: begin
        done      = 1'b1;
        cnt_nxt   = '0;
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
    if (last) cnt_nxt = '0;
    if (abort && state != S_IDLE) begin
      state_nxt = S_IDLE;
      cnt_nxt   = '0;
    end
  end

  // Columns/rows are shifted in last-first so word 0 ends nearest the array edge
  assign stage_wr_idx = IW'(cnt - CW'(1));
  assign stage_rd_idx = LW'(N - 1) - LW'(cnt);

  sa_operand_stage #(
    .N  (N),
    .DW (DW)
  ) u_stage (
    .clk     (clk),
    .wr_en   (stage_wr_en),
    .wr_idx  (stage_wr_idx),
    .wr_data (mem_rd_data),
    .rd_idx  (stage_rd_idx),
    .rd_a    (stage_rd_a),
    .rd_b    (stage_rd_b)
  );

endmodule

// File: tb/tb_sa_job_sequencer.sv
// tb/tb_sa_job_sequencer.sv - self-checking bench for sa_job_sequencer
module tb_sa_job_sequencer;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int AW = 8;
  localparam int CC = 15;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [7:0]  base_a = '0, base_b = '0, base_c = '0;
  logic        busy, done, mem_rd_en, sa_rstn, sa_en, res_wr_en;
  logic [7:0]  mem_rd_addr, res_wr_addr;
  logic [31:0] mem_rd_data = '0;
  logic [31:0] sa_shift_a, sa_shift_b, sa_shift_out, res_wr_data;

  always #5 clk = ~clk;

  sa_job_sequencer #(
    .N (N), .DW (DW), .AW (AW), .COMPUTE_CYCLES (CC)
  ) dut (
    .clk (clk), .rst (rst), .start (start), .abort (abort),
    .base_a (base_a), .base_b (base_b), .base_c (base_c),
    .busy (busy), .done (done),
    .mem_rd_en (mem_rd_en), .mem_rd_addr (mem_rd_addr), .mem_rd_data (mem_rd_data),
    .sa_rstn (sa_rstn), .sa_en (sa_en),
    .sa_shift_a (sa_shift_a), .sa_shift_b (sa_shift_b), .sa_shift_out (sa_shift_out),
    .res_wr_en (res_wr_en), .res_wr_addr (res_wr_addr), .res_wr_data (res_wr_data)
  );

  typedef struct packed {
    logic        busy, done, rd_en;
    logic [7:0]  rd_addr;
    logic        rstn, en;
    logic [31:0] sa, sb;
    logic        wr_en;
    logic [7:0]  wr_addr;
    logic [31:0] wr_data;
  } obs_t;

  typedef struct {
    string           name;
    int              kind;       // 0 case1, 1 case2, 2 random matrices
    logic [7:0]      ba, bb, bc;
    int              st1, st2;   // extra start pulses while busy (0 = none)
    int              abort_at, rst_at;
    int              last_busy;  // last cycle with busy=1
    logic [3:0][31:0] rows;      // expected result words
  } scn_t;

  logic [31:0] mem [256];
  int ma [4][4];
  int mb [4][4];
  int checks = 0;
  int errors = 0;

  always @(posedge clk) if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];

  // Array model: accumulate outer products of whatever was loaded since the last clear
  logic [31:0]      wa [4];
  logic [31:0]      wb [4];
  logic [3:0][31:0] prod = '0;
  int ld_cnt = 0;
  int since = 0;

  function automatic logic [3:0][31:0] wrap_product();
    logic [3:0][31:0] p;
    int acc;
    for (int j = 0; j < 4; j++)
      for (int c = 0; c < 4; c++) begin
        acc = 0;
        for (int s = 0; s < 4; s++) acc += int'(wa[s][j*8 +: 8]) * int'(wb[s][c*8 +: 8]);
        p[j][c*8 +: 8] = 8'(acc);
      end
    return p;
  endfunction

  always @(posedge clk) begin
    if (!sa_rstn) begin
      ld_cnt <= 0;
      since  <= 0;
    end else if (sa_en) begin
      if (ld_cnt < 4) begin
        wa[ld_cnt] <= sa_shift_a;
        wb[ld_cnt] <= sa_shift_b;
      end
      ld_cnt <= ld_cnt + 1;
      since  <= 0;
    end else begin
      since <= since + 1;
      if (since == 0) prod <= wrap_product();
    end
  end

  always_comb begin
    sa_shift_out = 32'hA5A5_A5A5;
    if (ld_cnt == 4 && since >= CC && since < CC + 4) sa_shift_out = prod[since - CC];
  end

  function automatic logic [31:0] col_a(input int k);
    logic [31:0] w;
    for (int r = 0; r < 4; r++) w[r*8 +: 8] = 8'(ma[r][k]);
    return w;
  endfunction

  function automatic logic [31:0] row_b(input int k);
    logic [31:0] w;
    for (int c = 0; c < 4; c++) w[c*8 +: 8] = 8'(mb[k][c]);
    return w;
  endfunction

  function automatic logic [31:0] ref_row(input int j);
    logic [31:0] w;
    int acc;
    for (int c = 0; c < 4; c++) begin
      acc = 0;
      for (int k = 0; k < 4; k++) acc += ma[j][k] * mb[k][c];
      w[c*8 +: 8] = 8'(acc);
    end
    return w;
  endfunction

  function automatic obs_t idle_obs();
    obs_t e = '0;
    e.rstn = 1'b1;
    return e;
  endfunction

  function automatic obs_t sample();
    obs_t o;
    o.busy = busy;     o.done = done;     o.rd_en = mem_rd_en; o.rd_addr = mem_rd_addr;
    o.rstn = sa_rstn;  o.en = sa_en;      o.sa = sa_shift_a;   o.sb = sa_shift_b;
    o.wr_en = res_wr_en; o.wr_addr = res_wr_addr; o.wr_data = res_wr_data;
    return o;
  endfunction

  // Expected outputs in cycle t after the accepting edge, from the job timeline
  function automatic obs_t expect_at(input scn_t s, input int t);
    obs_t e = idle_obs();
    if (t >= 1 && t <= s.last_busy) begin
      e.busy = 1'b1;
      if (t <= 4) begin e.rd_en = 1'b1; e.rd_addr = s.ba + 8'(t - 1); end
      else if (t <= 8) begin e.rd_en = 1'b1; e.rd_addr = s.bb + 8'(t - 5); end
      if (t == 10 || t == 11) e.rstn = 1'b0;
      if (t >= 12 && t <= 15) begin e.en = 1'b1; e.sa = col_a(15 - t); e.sb = row_b(15 - t); end
      if (t >= 31 && t <= 34) begin
        e.wr_en = 1'b1; e.wr_addr = s.bc + 8'(t - 31); e.wr_data = s.rows[t - 31];
      end
      if (t == 35) e.done = 1'b1;
    end
    return e;
  endfunction

  task automatic check(input string what, input int t, input obs_t act, input obs_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", what, t, act, exp);
    end
  endtask

  task automatic load_mem(input scn_t s);
    if (s.kind == 0) begin
      for (int i = 0; i < 4; i++)
        for (int j = 0; j < 4; j++) begin ma[i][j] = j + 1; mb[i][j] = i + 1; end
    end else if (s.kind == 1) begin
      for (int i = 0; i < 4; i++)
        for (int j = 0; j < 4; j++) begin
          ma[i][j] = (i == 0 || i == 3 || j == 0 || j == 3) ? 1 : 0;
          mb[i][j] = 2 * (4 * i + j) + 12;
        end
    end
    for (int k = 0; k < 4; k++) begin
      mem[s.ba + 8'(k)] = col_a(k);
      mem[s.bb + 8'(k)] = row_b(k);
    end
  endtask

  task automatic run_scn(input scn_t s);
    load_mem(s);
    @(negedge clk);
    base_a = s.ba; base_b = s.bb; base_c = s.bc;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    base_a = ~s.ba; base_b = ~s.bb; base_c = ~s.bc;
    for (int t = 1; t <= 40; t++) begin
      @(negedge clk);
      check(s.name, t, sample(), expect_at(s, t));
      start = (t == s.st1 || t == s.st2);
      abort = (t == s.abort_at);
      if (t == s.rst_at) begin
        rst = 1'b1;
        #1;
        check({s.name, " reset value"}, t, sample(), idle_obs());
      end else begin
        rst = 1'b0;
      end
    end
    start = 1'b0; abort = 1'b0; rst = 1'b0;
  endtask

  localparam logic [3:0][31:0] ROWS1 = {4{32'h1E1E_1E1E}};
  localparam logic [3:0][31:0] ROWS2 = {32'h7870_6860, 32'h3C38_3430, 32'h3C38_3430, 32'h7870_6860};

  scn_t scns [8];
  scn_t rs;

  initial begin
    scns[0] = '{"case1",          0, 8'h10, 8'h20, 8'h30, 0,  0,  0,  0, 35, ROWS1};
    scns[1] = '{"case2",          1, 8'h40, 8'h50, 8'h60, 0,  0,  0,  0, 35, ROWS2};
    scns[2] = '{"addr wrap",      0, 8'hFE, 8'h80, 8'hFD, 0,  0,  0,  0, 35, ROWS1};
    scns[3] = '{"ignored start",  1, 8'h00, 8'h04, 8'h08, 5, 35,  0,  0, 35, ROWS2};
    scns[4] = '{"abort compute",  0, 8'h10, 8'h20, 8'h30, 0,  0, 20,  0, 20, ROWS1};
    scns[5] = '{"after abort",    0, 8'h11, 8'h21, 8'h31, 0,  0,  0,  0, 35, ROWS1};
    scns[6] = '{"reset in drain", 0, 8'h10, 8'h20, 8'h30, 0,  0,  0, 32, 32, ROWS1};
    scns[7] = '{"after reset",    0, 8'h12, 8'h22, 8'h32, 0,  0,  0,  0, 35, ROWS1};

    #2 rst = 1'b1;
    #1 check("reset state", 0, sample(), idle_obs());
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("idle after reset", 0, sample(), idle_obs());
    abort = 1'b1;
    @(negedge clk);
    check("abort in idle", 0, sample(), idle_obs());
    abort = 1'b0;

    for (int i = 0; i < 8; i++) run_scn(scns[i]);

    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 4; i++)
        for (int j = 0; j < 4; j++) begin
          ma[i][j] = int'($urandom_range(0, 255));
          mb[i][j] = int'($urandom_range(0, 255));
        end
      rs.name      = "random";
      rs.kind      = 2;
      rs.ba        = 8'($urandom);
      rs.bb        = rs.ba + 8'(4 + $urandom_range(0, 248));
      rs.bc        = 8'($urandom);
      rs.st1       = int'($urandom_range(1, 35));
      rs.st2       = 0;
      rs.abort_at  = 0;
      rs.rst_at    = 0;
      rs.last_busy = 35;
      for (int j = 0; j < 4; j++) rs.rows[j] = ref_row(j);
      run_scn(rs);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
